// File: rtl/operate_uart_sender_pkg.sv
// Shared operation codes emitted by the traveler button/operate stage.
// OPERATE_IGNORE marks a cycle with no command. Every other value is a command byte.
package operate_uart_sender_pkg;

  localparam logic [7:0] OPERATE_IGNORE = 8'h00;
  localparam logic [7:0] OPERATE_UP     = 8'h01;
  localparam logic [7:0] OPERATE_DOWN   = 8'h02;
  localparam logic [7:0] OPERATE_LEFT   = 8'h03;
  localparam logic [7:0] OPERATE_RIGHT  = 8'h04;
  localparam logic [7:0] OPERATE_SELECT = 8'h05;

endpackage

// File: rtl/operate_uart_sender_if.sv
// Bundles the command input, the serial output and the status lines.
// The operate stage and the bench use the master modport. The sender uses the slave modport.
interface operate_uart_sender_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    op_data;
  logic          overflow_clr;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  modport master (
    output op_data, overflow_clr,
    input  tx, busy, overflow, fifo_count
  );

  modport slave (
    input  op_data, overflow_clr,
    output tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/operate_uart_sender_op_fifo.sv
// Small synchronous FIFO with a show-ahead read port.
// pop_data is valid whenever empty is low. A push while full or a pop while empty is ignored.
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array write.
  // NOTE: the array has no reset. Resetting the pointers and count is enough to empty the FIFO, and leaving the array unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/operate_uart_sender.sv
// Queues every non-ignore operation code and sends each one as a UART 8N1 frame, LSB first.
// Frames are 10*BAUD_DIV cycles long. Queued codes go out back to back with no idle gap.
module operate_uart_sender
  import operate_uart_sender_pkg::*;
#(
  parameter int         BAUD_DIV    = 10417,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] IGNORE_CODE = OPERATE_IGNORE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operate_uart_sender_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  tx_state_e     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_q;
  logic          overflow_q;

  logic          cmd;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;
  logic          bit_end;

  assign cmd     = (bus.op_data != IGNORE_CODE);
  assign bit_end = (baud_cnt == BW'(BAUD_DIV - 1));

  // A code is taken from the queue when an idle FSM sees data, or on the last stop-bit cycle so the next frame starts without a gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  op_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd && !fifo_full),
    .push_data (bus.op_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow flag. A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (cmd && fifo_full) begin
      overflow_q <= 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

  // Transmit FSM. tx is loaded with the value of the bit that starts on the next cycle, so the line comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          tx_q     <= 1'b1;
          if (!fifo_empty) begin
            shift <= fifo_data;
            state <= ST_START;
            tx_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shift <= fifo_data;
              state <= ST_START;
              tx_q  <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = fifo_count;
  assign bus.busy       = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_operate_uart_sender.sv
// Directed bench for operate_uart_sender with BAUD_DIV=4, FIFO_DEPTH=4, IGNORE_CODE=00.
// A line monitor captures every frame cycle by cycle and compares it with the byte at the head of the scoreboard.
module tb_operate_uart_sender;
  import operate_uart_sender_pkg::*;

  localparam int BAUD_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * BAUD_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operate_uart_sender_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  operate_uart_sender #(
    .BAUD_DIV    (BAUD_DIV),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .IGNORE_CODE (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] sb[$];
  int         frame_starts[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for each cycle of a frame: start 0, data LSB first, stop 1.
  function automatic logic [63:0] frame_bits(input logic [7:0] b);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < FRAME; k++) begin
      int idx;
      idx = k / BAUD_DIV;
      if (idx == 0)      v[k] = 1'b0;
      else if (idx == 9) v[k] = 1'b1;
      else               v[k] = b[idx-1];
    end
    return v;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(bus.busy), 64'd0);
  endtask

  // Line monitor. Samples tx on falling edges. A frame cut short by reset is discarded.
  initial begin : monitor
    logic [63:0] obs;
    logic [7:0]  exp_byte;
    bit          aborted;
    int          start;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx === 1'b0) begin
        obs     = '0;
        aborted = 1'b0;
        start   = cyc;
        obs[0]  = bus.tx;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          obs[k] = bus.tx;
        end
        if (!aborted) begin
          frame_starts.push_back(start);
          check("mon_frame_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            exp_byte = sb.pop_front();
            check($sformatf("mon_frame_%02h", exp_byte), obs, frame_bits(exp_byte));
          end
        end
      end
    end
  end

  initial begin : stimulus
    bus.op_data      = 8'h00;
    bus.overflow_clr = 1'b0;
    rst_n            = 1'b0;
    step(3);
    rst_n = 1'b1;

    // 1: quiet line after reset
    for (int i = 0; i < 100; i++) begin
      step();
      check("t1_idle", 64'({bus.tx, bus.busy, bus.overflow, bus.fifo_count}), 64'b100000);
    end

    // 2: single code 0A, latency and busy window
    bus.op_data = 8'h0A;
    sb.push_back(8'h0A);
    step();
    bus.op_data = 8'h00;
    check("t2_count_after_push", 64'(bus.fifo_count), 64'd1);
    check("t2_tx_before_pop", 64'(bus.tx), 64'd1);
    step();
    check("t2_tx_start", 64'(bus.tx), 64'd0);
    check("t2_count_after_pop", 64'(bus.fifo_count), 64'd0);
    step(39);
    check("t2_busy_in_stop", 64'(bus.busy), 64'd1);
    check("t2_tx_stop", 64'(bus.tx), 64'd1);
    step();
    check("t2_busy_done", 64'(bus.busy), 64'd0);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: 11 held three cycles gives three contiguous frames
    frame_starts.delete();
    bus.op_data = 8'h11;
    repeat (3) begin
      sb.push_back(8'h11);
      step();
    end
    bus.op_data = 8'h00;
    wait_idle(200, "t3_drain");
    check("t3_frames", 64'(frame_starts.size()), 64'd3);
    if (frame_starts.size() == 3) begin
      check("t3_gap1", 64'(frame_starts[1] - frame_starts[0]), 64'(FRAME));
      check("t3_gap2", 64'(frame_starts[2] - frame_starts[1]), 64'(FRAME));
    end
    check("t3_no_overflow", 64'(bus.overflow), 64'd0);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);

    // 4: six codes back to back, the sixth is dropped
    frame_starts.delete();
    for (int i = 1; i <= 6; i++) begin
      bus.op_data = 8'(i);
      if (i <= 5) sb.push_back(8'(i));
      step();
      if (i == 5) begin
        check("t4_full_count", 64'(bus.fifo_count), 64'd4);
        check("t4_no_overflow_yet", 64'(bus.overflow), 64'd0);
      end
    end
    bus.op_data = 8'h00;
    check("t4_overflow_set", 64'(bus.overflow), 64'd1);
    check("t4_count_after_drop", 64'(bus.fifo_count), 64'd4);
    wait_idle(400, "t4_drain");
    check("t4_frames", 64'(frame_starts.size()), 64'd5);
    if (frame_starts.size() == 5)
      check("t4_contiguous", 64'(frame_starts[4] - frame_starts[0]), 64'(4 * FRAME));
    check("t4_sb_empty", 64'(sb.size()), 64'd0);

    // 5: set wins over clear on the same edge, clear alone works
    bus.overflow_clr = 1'b1;
    step();
    bus.overflow_clr = 1'b0;
    check("t5_clear_initial", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < 5; i++) begin
      bus.op_data = 8'h21 + 8'(i);
      sb.push_back(8'h21 + 8'(i));
      step();
    end
    bus.op_data      = 8'h26;
    bus.overflow_clr = 1'b1;
    step();
    bus.op_data      = 8'h00;
    bus.overflow_clr = 1'b0;
    check("t5_set_wins", 64'(bus.overflow), 64'd1);
    step(3);
    check("t5_sticky", 64'(bus.overflow), 64'd1);
    bus.overflow_clr = 1'b1;
    step();
    bus.overflow_clr = 1'b0;
    check("t5_clear_alone", 64'(bus.overflow), 64'd0);
    wait_idle(400, "t5_drain");
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // 6: reset during data bit 3 with two codes queued
    frame_starts.delete();
    bus.op_data = 8'h31;
    step();
    bus.op_data = 8'h32;
    step();
    bus.op_data = 8'h33;
    step();
    bus.op_data = 8'h00;
    check("t6_queued", 64'(bus.fifo_count), 64'd2);
    step(16);
    check("t6_tx_bit3", 64'(bus.tx), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_tx_reset", 64'(bus.tx), 64'd1);
    check("t6_count_reset", 64'(bus.fifo_count), 64'd0);
    check("t6_busy_reset", 64'(bus.busy), 64'd0);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("t6_quiet", 64'({bus.tx, bus.busy}), 64'b10);
    end
    check("t6_no_frame", 64'(frame_starts.size()), 64'd0);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operate_uart_sender.md
Name: operate_uart_sender

Overview:
- Downstream of the traveler button/operate stage, which emits one 8-bit operation code for one cycle per debounced press and `OPERATE_IGNORE` otherwise.
- Captures every non-ignore code into a small FIFO.
- Serialises each code to the host as a UART 8N1 frame, LSB first.
- Sits between the operate stage and the board TX pin.

Parameters:
- `BAUD_DIV`, 10417: clock cycles per UART bit (100 MHz / 9600 baud).
- `FIFO_DEPTH`, 4: number of queued operation codes; power of two, ≥2.
- `IGNORE_CODE`, `` `OPERATE_IGNORE ``: input value meaning "no command"; never queued.

Ports:
- `clk`  input  1  system clock
- `rst_n`  input  1  asynchronous active-low reset
- `op_data`  input  8  operation code from the operate stage; any value ≠ `IGNORE_CODE` is a command
- `overflow_clr`  input  1  synchronous clear of `overflow`
- `tx`  output  1  UART serial line, idle high
- `busy`  output  1  high when FSM ≠ IDLE or FIFO count ≠ 0
- `overflow`  output  1  sticky: a command was dropped because the FIFO was full
- `fifo_count`  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, `rst_n`=0): `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, FSM=IDLE, FIFO emptied, baud counter=0. Takes effect immediately, including mid-frame. Nothing resumes after release.
- Capture:
  - At each posedge, if `op_data` ≠ `IGNORE_CODE`, push `op_data`.
  - Each cycle counts separately: a code held N cycles yields N pushes.
  - Full check uses the registered count before the edge. A push when count = `FIFO_DEPTH` is dropped and sets `overflow`, even if a pop happens the same edge.
- `overflow`: set on drop; cleared by `overflow_clr`=1. Set wins if both occur on the same edge.
- Simultaneous push and pop with count < `FIFO_DEPTH`: both happen, count unchanged.
- TX FSM states: IDLE, START, DATA, STOP. The baud counter runs 0..`BAUD_DIV`-1 within each bit.
  - IDLE: `tx`=1. If count > 0, pop into an 8-bit shift register, go to START, counter=0.
  - START: `tx`=0 for `BAUD_DIV` cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[0] for `BAUD_DIV` cycles per bit. Shift right at each bit end. After bit 7, go to STOP.
  - STOP: `tx`=1 for `BAUD_DIV` cycles. On the last cycle:
    - if count > 0, pop and go directly to START (no idle gap);
    - else go to IDLE.
- `tx` is registered, glitch-free, and exactly 1 during IDLE.
- Latency: push at edge E into an empty FIFO with IDLE FSM → pop at E+1, `tx` falls after E+1.
- Frame length: exactly 10×`BAUD_DIV` cycles. Back-to-back frames are contiguous.
- `fifo_count` wraps never; read and write pointers wrap modulo `FIFO_DEPTH`.
- `busy` is combinational from registered state and count.

Decomposition:
- `Define.v` (shared include) holds the `OPERATE_*` codes including `OPERATE_IGNORE`. No new constants beyond the FSM state encodings, which stay local.
- One sub-module: `op_fifo`, a synchronous FIFO with push/pop/full/empty/count and parameter depth and width. The top holds the capture logic, baud counter, and TX FSM.

Test Plan (`BAUD_DIV`=4, `FIFO_DEPTH`=4, `IGNORE_CODE`=8'h00):
1. Reset held, then released with `op_data`=00 → `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0 throughout 100 cycles.
2. `op_data`=8'h0A for one cycle at edge E → `tx`=0 for cycles E+1..E+4; then bits 0,1,0,1,0,0,0,0, each 4 cycles; stop 1 for 4 cycles; `busy` low after 40 cycles.
3. 8'h11 held 3 cycles → three consecutive 40-cycle frames of 0x11, no idle gap, `overflow`=0.
4. Six distinct codes 01..06 on six consecutive cycles → codes 01..05 are sent in order (200 contiguous cycles). 06 is dropped, `overflow`=1 from the sixth edge.
5. Pulse `overflow_clr` while a drop occurs the same edge → `overflow` stays 1. A clear pulse alone later → `overflow`=0.
6. `rst_n`=0 during DATA bit 3 of a frame with 2 queued → `tx`=1 immediately, `fifo_count`=0. After release no frame appears within 100 cycles.
